uart_rx_param: RTL and testbench

Parametrised UART receiver for the FPGA pattern-matching datapath; next generation of the fixed 8-bit, 104-clock serial receiver. It converts an asynchronous serial line into words with configurable bit period, data width, parity mode and stop-bit count. It adds a metastability synchroniser, start-bit glitch rejection, parity and framing error reporting, and a one-entry valid/ready output buffer with sticky overrun. It sits between the board RX pin and the pattern-matcher input stage.

---
 rtl/uart_rx_param_if.sv | 13 +
 rtl/uart_rx_param.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx_param.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_param_if.sv
// Word-side handshake of the UART receiver: held word plus its error flags, with valid/ready flow control.
interface uart_rx_param_if #(
  parameter int unsigned DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] oDATA;
  logic                 oVALID;
  logic                 oPERR;
  logic                 oFERR;
  logic                 iREADY;

  modport master (output oDATA, output oVALID, output oPERR, output oFERR, input iREADY);
  modport slave  (input oDATA, input oVALID, input oPERR, input oFERR, output iREADY);
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: two-flop synchroniser, glitch-rejecting start detection,
// parity/framing checks and a one-entry valid/ready word buffer with sticky overrun.
module uart_rx_param #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic            clk_s,
  input  logic            rstn_s,
  input  logic            iDATA,
  input  logic            iCLR,
  output logic            oOVR,
  output logic            oBUSY,
  uart_rx_param_if.master rx_if
);
  localparam int unsigned CW = 16;
  localparam int unsigned IW = 4;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
  localparam bit            HAS_PAR   = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync2_q, rx_s;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 pbit_q, pbit_d;
  logic                 ferr_q, ferr_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 bit_tick, frame_perr;

  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, perr_q, ferr_out_q, ovr_q;

  // Metastability synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk_s or negedge rstn_s) begin
    if (!rstn_s) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= iDATA;
      sync2_q <= sync1_q;
    end
  end
  assign rx_s = sync2_q;

  always_ff @(posedge clk_s or negedge rstn_s) begin
    if (!rstn_s) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      pbit_q  <= 1'b0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      pbit_q  <= pbit_d;
      ferr_q  <= ferr_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bit_tick = (cnt_q == BIT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    pbit_d  = pbit_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) begin
          state_d = S_START;
          ferr_d  = 1'b0;
        end
      end
      // Mid-bit check of the start bit rejects short low glitches.
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (idx_q == DATA_LAST) begin
            idx_d   = '0;
            state_d = HAS_PAR ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_tick) begin
          cnt_d   = '0;
          pbit_d  = rx_s;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_tick) begin
          cnt_d = '0;
          if (!rx_s) ferr_d = 1'b1;
          if (idx_q == STOP_LAST) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = ferr_d ? S_WAIT_IDLE : S_IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      // A held-low break line is reported once, then ignored until it returns high.
      S_WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE) | done_d;
  end

  always_comb begin
    frame_perr = 1'b0;
    if (PARITY == 1)      frame_perr = ^shift_q ^ pbit_q;
    else if (PARITY == 2) frame_perr = ~(^shift_q ^ pbit_q);
  end

  // One-entry output buffer; a completed word arriving while it is full is dropped.
  always_ff @(posedge clk_s or negedge rstn_s) begin
    if (!rstn_s) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      if (done_q) begin
        if (!valid_q || rx_if.iREADY) begin
          data_q     <= shift_q;
          valid_q    <= 1'b1;
          perr_q     <= frame_perr;
          ferr_out_q <= ferr_q;
        end
      end else if (valid_q && rx_if.iREADY) begin
        data_q     <= '0;
        valid_q    <= 1'b0;
        perr_q     <= 1'b0;
        ferr_out_q <= 1'b0;
      end
      if (done_q && valid_q && !rx_if.iREADY) ovr_q <= 1'b1;
      else if (iCLR)                          ovr_q <= 1'b0;
    end
  end

  assign rx_if.oDATA  = data_q;
  assign rx_if.oVALID = valid_q;
  assign rx_if.oPERR  = perr_q;
  assign rx_if.oFERR  = ferr_out_q;
  assign oOVR         = ovr_q;
  assign oBUSY        = busy_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: directed scenarios on an 8N1 receiver plus randomized frames on
// 7E2 and 5O1 variants, checked against a frame-level reference model.
module tb_uart_rx_param;
  localparam int unsigned NDUT = 3;
  localparam int unsigned CPB0 = 104;
  localparam int unsigned CPB1 = 16;
  localparam int unsigned CPB2 = 9;

  logic clk_s = 1'b0;
  logic rstn_s;
  always #5 clk_s = ~clk_s;

  logic       line [NDUT];
  logic       rdy  [NDUT];
  logic       clr  [NDUT];
  logic       vld  [NDUT];
  logic       prr  [NDUT];
  logic       frr  [NDUT];
  logic       ovr  [NDUT];
  logic       bsy  [NDUT];
  logic [8:0] dat  [NDUT];

  int n_chk = 0;
  int n_pass = 0;
  logic [12:0] exp_q[$];
  logic [12:0] got_q[$];

  uart_rx_param_if #(.DATA_BITS(8)) if0 ();
  uart_rx_param_if #(.DATA_BITS(7)) if1 ();
  uart_rx_param_if #(.DATA_BITS(5)) if2 ();

  uart_rx_param dut0 (
    .clk_s(clk_s), .rstn_s(rstn_s), .iDATA(line[0]), .iCLR(clr[0]),
    .oOVR(ovr[0]), .oBUSY(bsy[0]), .rx_if(if0)
  );
  uart_rx_param #(.CLKS_PER_BIT(CPB1), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut1 (
    .clk_s(clk_s), .rstn_s(rstn_s), .iDATA(line[1]), .iCLR(clr[1]),
    .oOVR(ovr[1]), .oBUSY(bsy[1]), .rx_if(if1)
  );
  uart_rx_param #(.CLKS_PER_BIT(CPB2), .DATA_BITS(5), .PARITY(2), .STOP_BITS(1)) dut2 (
    .clk_s(clk_s), .rstn_s(rstn_s), .iDATA(line[2]), .iCLR(clr[2]),
    .oOVR(ovr[2]), .oBUSY(bsy[2]), .rx_if(if2)
  );

  assign if0.iREADY = rdy[0];
  assign if1.iREADY = rdy[1];
  assign if2.iREADY = rdy[2];

  always_comb begin
    vld[0] = if0.oVALID; prr[0] = if0.oPERR; frr[0] = if0.oFERR; dat[0] = 9'(if0.oDATA);
    vld[1] = if1.oVALID; prr[1] = if1.oPERR; frr[1] = if1.oFERR; dat[1] = 9'(if1.oDATA);
    vld[2] = if2.oVALID; prr[2] = if2.oPERR; frr[2] = if2.oFERR; dat[2] = 9'(if2.oDATA);
  end

  // Records every accepted word as {dut, ferr, perr, data}.
  always @(posedge clk_s) begin
    for (int d = 0; d < int'(NDUT); d++)
      if (vld[d] && rdy[d]) got_q.push_back({2'(d), frr[d], prr[d], dat[d]});
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Drives one frame at negedges; lastv is the value of the final stop bit.
  task automatic send(input int d, input int cpb, input int nb, input int par,
                      input logic [8:0] w, input logic pbit, input int stops, input logic lastv);
    logic q[$];
    q.push_back(1'b0);
    for (int i = 0; i < nb; i++) q.push_back(w[i]);
    if (par != 0) q.push_back(pbit);
    for (int i = 0; i < stops; i++) q.push_back((i == stops - 1) ? lastv : 1'b1);
    foreach (q[i]) begin
      @(negedge clk_s);
      line[d] = q[i];
      repeat (cpb - 1) @(negedge clk_s);
    end
    if (!lastv) begin
      @(negedge clk_s);
      line[d] = 1'b1;
      repeat (2 * cpb) @(negedge clk_s);
    end
  endtask

  // Expected delivered word, computed from the frame contents alone.
  function automatic logic [12:0] model(input int d, input int nb, input int par,
                                        input logic [8:0] w, input logic pbit, input logic lastv);
    logic [8:0] m;
    int         ones;
    logic       perr;
    m    = w & 9'((32'd1 << nb) - 1);
    ones = $countones(m) + int'(pbit);
    perr = (par == 1) ? (ones % 2 == 1) : (par == 2) ? (ones % 2 == 0) : 1'b0;
    return {2'(d), ~lastv, perr, m};
  endfunction

  task automatic pulse_rdy(input int d);
    @(negedge clk_s); rdy[d] = 1'b1;
    @(negedge clk_s); rdy[d] = 1'b0;
  endtask

  initial begin
    int k, kb, nbsy, nvld;
    logic [8:0] w;
    logic pb, lv;

    rstn_s = 1'b0;
    for (int d = 0; d < int'(NDUT); d++) begin
      line[d] = 1'b1; rdy[d] = 1'b0; clr[d] = 1'b0;
    end
    repeat (3) @(negedge clk_s);
    chk("reset valid", 16'(vld[0]), 16'd0);
    chk("reset busy", 16'(bsy[0]), 16'd0);
    chk("reset ovr", 16'(ovr[0]), 16'd0);
    rstn_s = 1'b1;
    repeat (5) @(negedge clk_s);
    chk("idle data", 16'(dat[0]), 16'd0);

    // 0xA5 8N1: latency of oBUSY and oVALID from t0.
    k = 0; kb = -1;
    fork
      send(0, CPB0, 8, 0, 9'h0A5, 1'b0, 1, 1'b1);
      begin
        @(negedge clk_s);
        for (k = 0; k < 1200; k++) begin
          @(posedge clk_s); #1;
          if (bsy[0] && kb < 0) kb = k;
          if (vld[0]) break;
        end
      end
    join
    chk("busy rise edge", 16'(kb), 16'd2);
    chk("valid rise edge", 16'(k), 16'd991);
    chk("A5 data", 16'(dat[0]), 16'h0A5);
    chk("A5 perr", 16'(prr[0]), 16'd0);
    chk("A5 ferr", 16'(frr[0]), 16'd0);
    chk("A5 busy after frame", 16'(bsy[0]), 16'd0);
    pulse_rdy(0);
    chk("A5 valid after accept", 16'(vld[0]), 16'd0);
    chk("A5 data after accept", 16'(dat[0]), 16'd0);

    // 20-cycle low glitch is rejected at the mid-start check.
    nbsy = 0; nvld = 0;
    fork
      begin @(negedge clk_s); line[0] = 1'b0; repeat (20) @(negedge clk_s); line[0] = 1'b1; end
      begin repeat (200) begin @(posedge clk_s); #1; nbsy += int'(bsy[0]); nvld += int'(vld[0]); end end
    join
    chk("glitch busy ~H", 16'(nbsy >= 51 && nbsy <= 53), 16'd1);
    chk("glitch no valid", 16'(nvld), 16'd0);
    send(0, CPB0, 8, 0, 9'h03C, 1'b0, 1, 1'b1);
    chk("3C after glitch", 16'(dat[0]), 16'h03C);
    chk("3C valid", 16'(vld[0]), 16'd1);
    pulse_rdy(0);

    // Break: line held low 3000 cycles gives exactly one framing-error word.
    @(negedge clk_s); line[0] = 1'b0;
    repeat (2000) @(negedge clk_s);
    chk("break valid", 16'(vld[0]), 16'd1);
    chk("break busy held", 16'(bsy[0]), 16'd1);
    repeat (1000) @(negedge clk_s);
    line[0] = 1'b1;
    repeat (300) @(negedge clk_s);
    chk("break data", 16'(dat[0]), 16'd0);
    chk("break ferr", 16'(frr[0]), 16'd1);
    chk("break perr", 16'(prr[0]), 16'd0);
    chk("break single word", 16'(ovr[0]), 16'd0);
    chk("break busy released", 16'(bsy[0]), 16'd0);
    pulse_rdy(0);
    send(0, CPB0, 8, 0, 9'h055, 1'b0, 1, 1'b1);
    chk("55 data", 16'(dat[0]), 16'h055);
    chk("55 ferr", 16'(frr[0]), 16'd0);
    pulse_rdy(0);

    // Overrun: second word dropped while the first is held.
    send(0, CPB0, 8, 0, 9'h011, 1'b0, 1, 1'b1);
    send(0, CPB0, 8, 0, 9'h022, 1'b0, 1, 1'b1);
    repeat (10) @(negedge clk_s);
    chk("ovr held data", 16'(dat[0]), 16'h011);
    chk("ovr flag", 16'(ovr[0]), 16'd1);
    @(negedge clk_s); clr[0] = 1'b1;
    @(negedge clk_s); clr[0] = 1'b0;
    chk("ovr cleared", 16'(ovr[0]), 16'd0);
    pulse_rdy(0);
    chk("ovr accept", 16'(vld[0]), 16'd0);
    send(0, CPB0, 8, 0, 9'h033, 1'b0, 1, 1'b1);
    chk("33 data", 16'(dat[0]), 16'h033);

    // Asynchronous reset in the middle of a 0xF0 frame, between clock edges.
    fork
      send(0, CPB0, 8, 0, 9'h0F0, 1'b0, 1, 1'b1);
      begin
        @(negedge clk_s);
        repeat (6 * CPB0 + 50) @(negedge clk_s);
        #2 rstn_s = 1'b0;
        #1;
        chk("async rst valid", 16'(vld[0]), 16'd0);
        chk("async rst data", 16'(dat[0]), 16'd0);
        chk("async rst busy", 16'(bsy[0]), 16'd0);
        #10 rstn_s = 1'b1;
      end
    join
    repeat (200) @(negedge clk_s);
    chk("partial frame dropped", 16'(vld[0]), 16'd0);
    send(0, CPB0, 8, 0, 9'h00F, 1'b0, 1, 1'b1);
    chk("0F data", 16'(dat[0]), 16'h00F);
    pulse_rdy(0);

    // Randomized frames on all variants with a consumer always ready.
    repeat (20) @(negedge clk_s);
    got_q.delete();
    exp_q.delete();
    for (int d = 0; d < int'(NDUT); d++) rdy[d] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      w = 9'($urandom_range(0, 255));
      exp_q.push_back(model(0, 8, 0, w, 1'b0, 1'b1));
      send(0, CPB0, 8, 0, w, 1'b0, 1, 1'b1);
    end
    for (int i = 0; i < 26; i++) begin
      w  = (i < 2) ? 9'h041 : 9'($urandom_range(0, 127));
      pb = (i < 2) ? 1'(i) : 1'($urandom_range(0, 1));
      lv = (i < 2) ? 1'b1 : ($urandom_range(0, 5) != 0);
      exp_q.push_back(model(1, 7, 1, w, pb, lv));
      send(1, CPB1, 7, 1, w, pb, 2, lv);
    end
    for (int i = 0; i < 30; i++) begin
      w  = 9'($urandom_range(0, 31));
      pb = 1'($urandom_range(0, 1));
      lv = ($urandom_range(0, 5) != 0);
      exp_q.push_back(model(2, 5, 2, w, pb, lv));
      send(2, CPB2, 5, 2, w, pb, 1, lv);
    end
    repeat (40) @(negedge clk_s);
    chk("word count", 16'(got_q.size()), 16'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) chk($sformatf("word %0d", i), 16'(got_q[i]), 16'(exp_q[i]));
    for (int d = 0; d < int'(NDUT); d++)
      chk($sformatf("no overrun dut%0d", d), 16'(ovr[d]), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
